// File: rtl/nvio_agen_pkg.sv
// Shared defaults and types for the agen scheduler.
package nvio_agen_pkg;

  localparam int unsigned DefQEntries = 8;
  localparam int unsigned DefTagW     = 3;
  localparam int unsigned DefWid      = 80;

  typedef logic [DefTagW-1:0] agen_tag_t;

  typedef struct packed {
    logic              v;
    agen_tag_t         id;
    logic [DefWid-1:0] ma;
    logic [DefWid-1:0] res2;
  } agen_res_t;

endpackage

// File: rtl/agen_rr_pick.sv
// Round-robin picker: first set bit of mask_i at or after start_i, wrapping, optionally
// skipping one id.
module agen_rr_pick
  import nvio_agen_pkg::*;
#(
  parameter int unsigned QENTRIES = DefQEntries,
  parameter int unsigned TAGW     = DefTagW
) (
  input  logic [QENTRIES-1:0] mask_i,
  input  logic [TAGW-1:0]     start_i,
  input  logic                excl_v_i,
  input  logic [TAGW-1:0]     excl_id_i,
  output logic                found_o,
  output logic [TAGW-1:0]     id_o
);

  logic [TAGW-1:0] idx;

  // Scan QENTRIES positions from start_i; TAGW-bit arithmetic wraps modulo QENTRIES.
  always_comb begin
    found_o = 1'b0;
    id_o    = '0;
    idx     = '0;
    for (int unsigned k = 0; k < QENTRIES; k++) begin
      idx = start_i + TAGW'(k);
      if (!found_o && mask_i[idx] && !(excl_v_i && (idx == excl_id_i))) begin
        found_o = 1'b1;
        id_o    = idx;
      end
    end
  end

endmodule

// File: rtl/agen_sched.sv
// Issues up to two ready load/store queue entries per cycle onto two agen units and
// holds each unit's result until the memory queue takes it.
module agen_sched
  import nvio_agen_pkg::*;
#(
  parameter int unsigned QENTRIES = DefQEntries,
  parameter int unsigned TAGW     = DefTagW,
  parameter int unsigned WID      = DefWid
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [QENTRIES-1:0] req_v,
  output logic [QENTRIES-1:0] issue_ack,
  output logic [1:0]          issue_v,
  output logic [2*TAGW-1:0]   issue_id,
  input  logic [1:0]          agen_idle,
  input  logic [2*WID-1:0]    agen_ma,
  input  logic [2*WID-1:0]    agen_res2,
  input  logic                kill_v,
  input  logic [QENTRIES-1:0] kill_mask,
  output logic [1:0]          res_v,
  output logic [2*TAGW-1:0]   res_id,
  output logic [2*WID-1:0]    res_ma,
  output logic [2*WID-1:0]    res_res2,
  input  logic [1:0]          res_rdy,
  output logic [31:0]         issue_cnt
);

  logic [QENTRIES-1:0] elig;
  logic [1:0]          avail;
  logic                found0, found1;
  logic [TAGW-1:0]     p0, p1, p1_start, last;

  logic [TAGW-1:0]     rr_q, rr_d;
  logic [1:0]          res_v_q, res_v_d;
  logic [2*TAGW-1:0]   res_id_q, res_id_d;
  logic [2*WID-1:0]    res_ma_q, res_ma_d;
  logic [2*WID-1:0]    res_res2_q, res_res2_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [32:0]         cnt_sum;

  // Killed entries never issue; a unit is free if idle and its result slot drains this cycle.
  always_comb begin
    elig     = req_v & ~(kill_v ? kill_mask : '0);
    avail    = agen_idle & (~res_v_q | res_rdy);
    p1_start = p0 + TAGW'(1);
  end

  agen_rr_pick #(
    .QENTRIES (QENTRIES),
    .TAGW     (TAGW)
  ) u_pick0 (
    .mask_i    (elig),
    .start_i   (rr_q),
    .excl_v_i  (1'b0),
    .excl_id_i ('0),
    .found_o   (found0),
    .id_o      (p0)
  );

  agen_rr_pick #(
    .QENTRIES (QENTRIES),
    .TAGW     (TAGW)
  ) u_pick1 (
    .mask_i    (elig),
    .start_i   (p1_start),
    .excl_v_i  (found0),
    .excl_id_i (p0),
    .found_o   (found1),
    .id_o      (p1)
  );

  // Map picks onto available units; with a single free unit it always takes p0.
  always_comb begin
    issue_v   = '0;
    issue_id  = '0;
    issue_ack = '0;
    last      = p0;
    if (avail == 2'b11) begin
      if (found0) begin
        issue_v[0]          = 1'b1;
        issue_id[0 +: TAGW] = p0;
      end
      if (found1) begin
        issue_v[1]             = 1'b1;
        issue_id[TAGW +: TAGW] = p1;
        last                   = p1;
      end
    end else if (avail[0]) begin
      if (found0) begin
        issue_v[0]          = 1'b1;
        issue_id[0 +: TAGW] = p0;
      end
    end else if (avail[1]) begin
      if (found0) begin
        issue_v[1]             = 1'b1;
        issue_id[TAGW +: TAGW] = p0;
      end
    end
    for (int unsigned u = 0; u < 2; u++) begin
      if (issue_v[u]) issue_ack[issue_id[u*TAGW +: TAGW]] = 1'b1;
    end
  end

  // Next-state: pointer, result slots (grant > kill > drain), saturating grant counter.
  always_comb begin
    rr_d       = (|issue_v) ? last + TAGW'(1) : rr_q;
    res_v_d    = res_v_q;
    res_id_d   = res_id_q;
    res_ma_d   = res_ma_q;
    res_res2_d = res_res2_q;
    for (int unsigned u = 0; u < 2; u++) begin
      if (issue_v[u]) begin
        res_v_d[u]              = 1'b1;
        res_id_d[u*TAGW +: TAGW] = issue_id[u*TAGW +: TAGW];
        res_ma_d[u*WID +: WID]   = agen_ma[u*WID +: WID];
        res_res2_d[u*WID +: WID] = agen_res2[u*WID +: WID];
      end else if (kill_v && kill_mask[res_id_q[u*TAGW +: TAGW]]) begin
        res_v_d[u] = 1'b0;
      end else if (res_rdy[u]) begin
        res_v_d[u] = 1'b0;
      end
    end
    cnt_sum = {1'b0, cnt_q} + 33'(issue_v[0]) + 33'(issue_v[1]);
    cnt_d   = cnt_sum[32] ? '1 : cnt_sum[31:0];
  end

  // State registers; reset drops any held results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= '0;
      res_v_q    <= '0;
      res_id_q   <= '0;
      res_ma_q   <= '0;
      res_res2_q <= '0;
      cnt_q      <= '0;
    end else begin
      rr_q       <= rr_d;
      res_v_q    <= res_v_d;
      res_id_q   <= res_id_d;
      res_ma_q   <= res_ma_d;
      res_res2_q <= res_res2_d;
      cnt_q      <= cnt_d;
    end
  end

  assign res_v     = res_v_q;
  assign res_id    = res_id_q;
  assign res_ma    = res_ma_q;
  assign res_res2  = res_res2_q;
  assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_agen_sched.sv
// Bench for agen_sched: directed vector table, async reset sequence, random traffic,
// all checked against a behavioural model of the scheduling rules.
module tb_agen_sched;
  import nvio_agen_pkg::*;

  localparam int Q  = 8;
  localparam int TW = 3;
  localparam int W  = 80;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [Q-1:0]    req_v, issue_ack, kill_mask;
  logic [1:0]      issue_v, agen_idle, res_v, res_rdy;
  logic [2*TW-1:0] issue_id, res_id;
  logic [2*W-1:0]  agen_ma, agen_res2, res_ma, res_res2;
  logic            kill_v;
  logic [31:0]     issue_cnt;
  logic [31:0]     salt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  agen_sched #(
    .QENTRIES (Q),
    .TAGW     (TW),
    .WID      (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_v     (req_v),
    .issue_ack (issue_ack),
    .issue_v   (issue_v),
    .issue_id  (issue_id),
    .agen_idle (agen_idle),
    .agen_ma   (agen_ma),
    .agen_res2 (agen_res2),
    .kill_v    (kill_v),
    .kill_mask (kill_mask),
    .res_v     (res_v),
    .res_id    (res_id),
    .res_ma    (res_ma),
    .res_res2  (res_res2),
    .res_rdy   (res_rdy),
    .issue_cnt (issue_cnt)
  );

  function automatic logic [W-1:0] mk_ma(input logic [2:0] id, input logic u,
                                         input logic [31:0] s);
    return {15'h0A0A, u, s, 29'h0, id};
  endfunction

  function automatic logic [W-1:0] mk_r2(input logic [2:0] id, input logic u,
                                         input logic [31:0] s);
    return {s ^ 32'h1234_5678, 7'h0, u, 37'h0, id};
  endfunction

  // Agen units: operands follow whatever id the scheduler presents.
  always_comb begin
    agen_ma   = {mk_ma(issue_id[5:3], 1'b1, salt), mk_ma(issue_id[2:0], 1'b0, salt)};
    agen_res2 = {mk_r2(issue_id[5:3], 1'b1, salt), mk_r2(issue_id[2:0], 1'b0, salt)};
  end

  // ---------------- reference model ----------------
  agen_res_t   m_res [2];
  int          m_rr;
  longint      m_cnt;
  logic [1:0]  e_iv;
  logic [2:0]  e_id0, e_id1;
  logic [7:0]  e_ack;
  int          e_p0, e_p1;

  task automatic model_reset();
    m_rr  = 0;
    m_cnt = 0;
    for (int u = 0; u < 2; u++) m_res[u] = '0;
  endtask

  task automatic model_comb(input logic [7:0] rq, input logic [1:0] idl, input logic kv,
                            input logic [7:0] km, input logic [1:0] rdy);
    logic [7:0] elig;
    logic [1:0] av;
    elig = rq & (kv ? ~km : 8'hFF);
    for (int u = 0; u < 2; u++) av[u] = idl[u] && (!m_res[u].v || rdy[u]);
    e_p0 = -1;
    e_p1 = -1;
    for (int k = 0; k < Q; k++) begin
      if (e_p0 < 0 && elig[(m_rr + k) % Q]) e_p0 = (m_rr + k) % Q;
    end
    if (e_p0 >= 0) begin
      for (int k = 1; k < Q; k++) begin
        if (e_p1 < 0 && elig[(e_p0 + k) % Q]) e_p1 = (e_p0 + k) % Q;
      end
    end
    e_iv  = 2'b00;
    e_id0 = 3'd0;
    e_id1 = 3'd0;
    if (av == 2'b11) begin
      if (e_p0 >= 0) begin e_iv[0] = 1'b1; e_id0 = 3'(e_p0); end
      if (e_p1 >= 0) begin e_iv[1] = 1'b1; e_id1 = 3'(e_p1); end
    end else if (av[0]) begin
      if (e_p0 >= 0) begin e_iv[0] = 1'b1; e_id0 = 3'(e_p0); end
    end else if (av[1]) begin
      if (e_p0 >= 0) begin e_iv[1] = 1'b1; e_id1 = 3'(e_p0); end
    end
    e_ack = 8'h00;
    if (e_iv[0]) e_ack = e_ack | (8'h01 << e_id0);
    if (e_iv[1]) e_ack = e_ack | (8'h01 << e_id1);
  endtask

  task automatic model_update(input logic kv, input logic [7:0] km, input logic [1:0] rdy);
    for (int u = 0; u < 2; u++) begin
      if (e_iv[u]) begin
        m_res[u].v    = 1'b1;
        m_res[u].id   = (u == 0) ? e_id0 : e_id1;
        m_res[u].ma   = mk_ma(m_res[u].id, 1'(u), salt);
        m_res[u].res2 = mk_r2(m_res[u].id, 1'(u), salt);
      end else if (kv && km[m_res[u].id]) begin
        m_res[u].v = 1'b0;
      end else if (rdy[u]) begin
        m_res[u].v = 1'b0;
      end
    end
    if (e_iv != 2'b00) m_rr = (((e_iv == 2'b11) ? e_p1 : e_p0) + 1) % Q;
    m_cnt = m_cnt + int'(e_iv[0]) + int'(e_iv[1]);
    if (m_cnt > 64'hFFFF_FFFF) m_cnt = 64'hFFFF_FFFF;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [1:0]  s_iv;
  logic [5:0]  s_id;
  logic [7:0]  s_ack;

  // One cycle: drive at posedge+1, check grants mid-cycle, check registers after the edge.
  task automatic step(input logic [7:0] rq, input logic [1:0] idl, input logic kv,
                      input logic [7:0] km, input logic [1:0] rdy);
    req_v     = rq;
    agen_idle = idl;
    kill_v    = kv;
    kill_mask = km;
    res_rdy   = rdy;
    salt      = $urandom;
    model_comb(rq, idl, kv, km, rdy);
    #4;
    s_iv  = issue_v;
    s_id  = issue_id;
    s_ack = issue_ack;
    chk("issue_v", 160'(issue_v), 160'(e_iv));
    chk("issue_id", 160'(issue_id), 160'({e_id1, e_id0}));
    chk("issue_ack", 160'(issue_ack), 160'(e_ack));
    @(posedge clk);
    model_update(kv, km, rdy);
    #1;
    chk("res_v", 160'(res_v), 160'({m_res[1].v, m_res[0].v}));
    chk("res_id", 160'(res_id), 160'({m_res[1].id, m_res[0].id}));
    chk("res_ma", 160'(res_ma), {m_res[1].ma, m_res[0].ma});
    chk("res_res2", 160'(res_res2), {m_res[1].res2, m_res[0].res2});
    chk("issue_cnt", 160'(issue_cnt), 160'(m_cnt[31:0]));
  endtask

  typedef struct packed {
    logic [7:0] rq;
    logic [1:0] idl;
    logic       kv;
    logic [7:0] km;
    logic [1:0] rdy;
    logic [1:0] x_iv;
    logic [2:0] x_id0;
    logic [2:0] x_id1;
    logic [7:0] x_ack;
    logic [1:0] x_rv;
  } vec_t;

  vec_t vecs [14];

  initial begin
    // rq, idle, kill_v, kill_mask, rdy | issue_v, id0, id1, ack, res_v after edge
    vecs[0]  = '{8'h06, 2'b11, 1'b0, 8'h00, 2'b00, 2'b11, 3'd1, 3'd2, 8'h06, 2'b11};
    vecs[1]  = '{8'h83, 2'b11, 1'b0, 8'h00, 2'b11, 2'b11, 3'd7, 3'd0, 8'h81, 2'b11};
    vecs[2]  = '{8'h04, 2'b11, 1'b0, 8'h00, 2'b11, 2'b01, 3'd2, 3'd0, 8'h04, 2'b01};
    vecs[3]  = '{8'h83, 2'b01, 1'b0, 8'h00, 2'b01, 2'b01, 3'd7, 3'd0, 8'h80, 2'b01};
    vecs[4]  = '{8'h83, 2'b01, 1'b0, 8'h00, 2'b01, 2'b01, 3'd0, 3'd0, 8'h01, 2'b01};
    vecs[5]  = '{8'h83, 2'b01, 1'b0, 8'h00, 2'b01, 2'b01, 3'd1, 3'd0, 8'h02, 2'b01};
    vecs[6]  = '{8'h83, 2'b01, 1'b0, 8'h00, 2'b01, 2'b01, 3'd7, 3'd0, 8'h80, 2'b01};
    vecs[7]  = '{8'h01, 2'b11, 1'b0, 8'h00, 2'b00, 2'b10, 3'd0, 3'd0, 8'h01, 2'b11};
    vecs[8]  = '{8'h02, 2'b11, 1'b0, 8'h00, 2'b01, 2'b01, 3'd1, 3'd0, 8'h02, 2'b11};
    vecs[9]  = '{8'h30, 2'b11, 1'b0, 8'h00, 2'b11, 2'b11, 3'd4, 3'd5, 8'h30, 2'b11};
    vecs[10] = '{8'h10, 2'b11, 1'b1, 8'h10, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 2'b10};
    vecs[11] = '{8'hFF, 2'b01, 1'b0, 8'h00, 2'b11, 2'b01, 3'd6, 3'd0, 8'h40, 2'b01};
    vecs[12] = '{8'h01, 2'b01, 1'b1, 8'h40, 2'b01, 2'b01, 3'd0, 3'd0, 8'h01, 2'b01};
    vecs[13] = '{8'h00, 2'b11, 1'b1, 8'h01, 2'b01, 2'b00, 3'd0, 3'd0, 8'h00, 2'b00};

    rst_n     = 1'b0;
    req_v     = '0;
    agen_idle = '0;
    kill_v    = 1'b0;
    kill_mask = '0;
    res_rdy   = '0;
    salt      = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_res_v", 160'(res_v), 160'(0));
    chk("reset_res_id", 160'(res_id), 160'(0));
    chk("reset_res_ma", 160'(res_ma), 160'(0));
    chk("reset_issue_cnt", 160'(issue_cnt), 160'(0));

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].rq, vecs[i].idl, vecs[i].kv, vecs[i].km, vecs[i].rdy);
      chk($sformatf("vec%0d_issue_v", i), 160'(s_iv), 160'(vecs[i].x_iv));
      chk($sformatf("vec%0d_issue_id", i), 160'(s_id), 160'({vecs[i].x_id1, vecs[i].x_id0}));
      chk($sformatf("vec%0d_issue_ack", i), 160'(s_ack), 160'(vecs[i].x_ack));
      chk($sformatf("vec%0d_res_v", i), 160'(res_v), 160'(vecs[i].x_rv));
    end
    chk("vec_issue_cnt", 160'(issue_cnt), 160'(32'd15));

    // Asynchronous reset in mid-cycle with both result slots full.
    step(8'h03, 2'b11, 1'b0, 8'h00, 2'b11);
    chk("pre_reset_res_v", 160'(res_v), 160'(2'b11));
    req_v     = '0;
    agen_idle = '0;
    res_rdy   = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_res_v", 160'(res_v), 160'(0));
    chk("async_issue_cnt", 160'(issue_cnt), 160'(0));
    chk("async_res_id", 160'(res_id), 160'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(8'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom),
           2'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/agen_sched.md
Name: agen_sched

Overview:
- Schedules address-generation work from the load/store queue onto two shared agen units (unit 0, unit 1).
- Each cycle it picks up to two ready queue entries round-robin and drives their ids to the operand muxes in front of the agen units.
- It captures each unit's ma/res2 into a per-unit result register and hands results to the memory queue over a valid/ready handshake.
- It also handles branch-miss kills.

Parameters:
- QENTRIES, 8, number of load/store queue entries (power of two, 4..16)
- TAGW, 3, entry id width, equal to log2(QENTRIES)
- WID, 80, address/data width of agen ma and res2

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous assert, active-low
- req_v  in  QENTRIES  entry i has operands ready and wants an agen
- issue_ack  out  QENTRIES  combinational; one-hot or two-hot mask of entries granted this cycle
- issue_v  out  2  unit u granted this cycle
- issue_id  out  2*TAGW  entry id for unit u; unit u occupies bits [u*TAGW +: TAGW]
- agen_idle  in  2  unit u can accept work
- agen_ma  in  2*WID  unit u ma (combinational from the operands selected by issue_id)
- agen_res2  in  2*WID  unit u res2
- kill_v  in  1  branch-miss cancel strobe
- kill_mask  in  QENTRIES  entries cancelled when kill_v is high
- res_v  out  2  result register u holds a valid result
- res_id  out  2*TAGW  entry id of result u
- res_ma  out  2*WID  registered ma
- res_res2  out  2*WID  registered res2
- res_rdy  in  2  memory queue accepts result u this cycle
- issue_cnt  out  32  count of grants since reset, saturating

Behaviour:
- Reset, asynchronous on rst_n low:
  - res_v=0; res_id, res_ma, res_res2 = 0.
  - Round-robin pointer rr=0; issue_cnt=0.
- Reset mid-operation drops all held results; there is no replay.
- Eligible set: elig = req_v & ~(kill_v ? kill_mask : 0).
- Unit u is available when agen_idle[u] & (~res_v[u] | res_rdy[u]). Consuming a result frees the unit in the same cycle.
- Grant selection (combinational):
  - First pick p0 = first set bit of elig scanning from rr upward, wrapping modulo QENTRIES.
  - Second pick p1 = next set bit after p0, same scan, excluding p0.
  - If both units are available: unit0←p0, unit1←p1.
  - If only one unit is available: that unit←p0.
  - With no eligible entry, the corresponding issue_v is 0. issue_id then holds 0.
  - issue_ack has a bit set for each granted entry.
- The queue clears req_v for an acked entry by the next cycle. The scheduler does not mask in-flight ids.
- Pointer update at the clock edge:
  - One or more grants: rr ← (last granted id + 1) mod QENTRIES, where last = p1 if it was granted, otherwise p0.
  - No grant: rr is unchanged.
- Latency: grant in cycle t; agen result captured at the end of cycle t; res_v high in cycle t+1.
- Result register update, per unit, at the clock edge:
  - If granted: load id, agen_ma, agen_res2; res_v←1.
  - Else if res_rdy & res_v: res_v←0.
  - Else: hold.
- res_* are stable while res_v & ~res_rdy.
- Kill:
  - When kill_v is high, any result register whose res_id is in kill_mask gets res_v←0 at the edge, even if res_rdy is high that cycle. The memory queue ignores killed results.
  - A new grant is never killed, because killed entries are excluded from elig.
  - Kill and a grant of a different id to the same unit in the same cycle: the grant wins.
- issue_cnt increments by popcount(issue_v) each cycle and saturates at 32'hFFFF_FFFF.
- Widths: all id arithmetic is modulo QENTRIES. ma and res2 pass through unmodified at WID bits.

Decomposition:
- Package nvio_agen_pkg holds:
  - QENTRIES, TAGW, WID defaults;
  - typedef agen_tag_t [TAGW-1:0];
  - typedef struct agen_res_t {v, id, ma, res2}.
- Sub-module agen_rr_pick:
  - Inputs: mask[QENTRIES], start pointer, exclude id/valid.
  - Outputs: found, id.
  - Instantiated twice, chained for p0 and p1.

Test Plan:
- Reset then req_v=8'b0000_0110, both units idle and res empty → unit0 id 1, unit1 id 2, issue_ack=0000_0110; next cycle res_v=2'b11, res_id={2,1}, rr=3.
- Fairness: rr=3, req_v=8'b1000_0011 → unit0 id 7, unit1 id 0, rr=1. Holding entries 0,1,7 requesting over 4 cycles, each with one unit available, grants 7,0,1,7 in turn.
- Backpressure: res_v[0]=1, res_rdy[0]=0, req_v=8'h01 → only unit1 grants id 0; res0 holds its values. Raise res_rdy[0] with req_v=8'h02 → unit0 grants id 1 that cycle, and res0 reloads without a bubble.
- Kill: res0 holds id 4, res1 holds id 5, res_rdy=0; kill_v=1, kill_mask=8'h10, req_v=8'h10 → no grant; next cycle res_v=2'b10.
- agen_idle=2'b01, req_v=8'hFF, rr=6 → unit0 id 6 only, issue_cnt+1, rr=7.
- Asynchronous reset: assert rst_n low mid-cycle with res_v=2'b11 → res_v and issue_cnt read 0 immediately, without waiting for a clock edge.
